// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider for DIV/DIVU in the EX stage.
// A start latches the operand magnitudes and the result signs. The divider then produces one
// quotient bit per cycle, applies the sign fix-up and presents {remainder, quotient} for the
// HI/LO write path. While a division is pending it asks ctrl to stall.
//
// Ports
//   clk               clock, rising edge
//   reset_n           asynchronous active-low reset
//   start_i           divide request; held high until ready_o is seen
//   annul_i           abort the current or pending division
//   signed_div_i      1 = DIV (signed), 0 = DIVU
//   opdata1_i         dividend
//   opdata2_i         divisor
//   result_o          {remainder (HI), quotient (LO)}
//   ready_o           result_o valid
//   stallreg_from_div stall request to ctrl
module div_seq #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreg_from_div
);

  localparam int unsigned CntW = $clog2(DATA_W) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W);

  typedef enum logic [1:0] {StIdle, StByZero, StOn, StEnd} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  // {partial remainder, remaining dividend bits / quotient bits, shift-in bit}
  logic [2*DATA_W:0]     dividend_q, dividend_d;
  logic [DATA_W-1:0]     divisor_q, divisor_d;
  logic                  quot_neg_q, quot_neg_d;
  logic                  rem_neg_q, rem_neg_d;
  logic [2*DATA_W-1:0]   result_d;
  logic                  ready_d;

  logic [DATA_W-1:0]     op1_abs, op2_abs;
  logic [DATA_W:0]       diff;
  logic [DATA_W-1:0]     quot_mag, rem_mag, quot_fix, rem_fix;

  // Magnitudes are divided unsigned, so 0x80000000 / -1 wraps back to 0x80000000.
  assign op1_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign op2_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  assign diff     = dividend_q[2*DATA_W:DATA_W] - {1'b0, divisor_q};
  assign quot_mag = dividend_q[DATA_W-1:0];
  assign rem_mag  = dividend_q[2*DATA_W:DATA_W+1];
  assign quot_fix = quot_neg_q ? -quot_mag : quot_mag;
  assign rem_fix  = rem_neg_q ? -rem_mag : rem_mag;

  assign stallreg_from_div = start_i & ~ready_o & ~annul_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    result_d   = result_o;
    ready_d    = ready_o;

    unique case (state_q)
      StIdle: begin
        if (start_i && !annul_i) begin
          cnt_d      = '0;
          dividend_d = {{DATA_W{1'b0}}, op1_abs, 1'b0};
          divisor_d  = op2_abs;
          quot_neg_d = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          rem_neg_d  = signed_div_i & opdata1_i[DATA_W-1];
          state_d    = (opdata2_i == '0) ? StByZero : StOn;
        end
      end
      StByZero: begin
        result_d = '0;
        if (annul_i) begin
          ready_d = 1'b0;
          state_d = StIdle;
        end else begin
          ready_d = 1'b1;
          state_d = StEnd;
        end
      end
      StOn: begin
        if (annul_i) begin
          result_d = '0;
          ready_d  = 1'b0;
          state_d  = StIdle;
        end else if (cnt_q != CntLast) begin
          // Restoring step: keep the subtraction only when it does not go negative.
          if (diff[DATA_W]) begin
            dividend_d = {dividend_q[2*DATA_W-1:0], 1'b0};
          end else begin
            dividend_d = {diff[DATA_W-1:0], dividend_q[DATA_W-1:0], 1'b1};
          end
          cnt_d = cnt_q + CntW'(1);
        end else begin
          result_d = {rem_fix, quot_fix};
          ready_d  = 1'b1;
          state_d  = StEnd;
        end
      end
      StEnd: begin
        if (!start_i) begin
          result_d = '0;
          ready_d  = 1'b0;
          state_d  = StIdle;
        end
      end
      default: begin
        result_d = '0;
        ready_d  = 1'b0;
        state_d  = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      result_o   <= '0;
      ready_o    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      result_o   <= result_d;
      ready_o    <= ready_d;
    end
  end

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           start_i = 1'b0;
  logic           annul_i = 1'b0;
  logic           signed_div_i = 1'b0;
  logic [W-1:0]   opdata1_i = '0;
  logic [W-1:0]   opdata2_i = '0;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           stallreg_from_div;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_seq #(.DATA_W(W)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start_i          (start_i),
    .annul_i          (annul_i),
    .signed_div_i     (signed_div_i),
    .opdata1_i        (opdata1_i),
    .opdata2_i        (opdata2_i),
    .result_o         (result_o),
    .ready_o          (ready_o),
    .stallreg_from_div(stallreg_from_div)
  );

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic. SV signed / and % truncate toward zero, so the
  // remainder already takes the dividend's sign.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return 64'd0;
    if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end
    return {r, q};
  endfunction

  // Starts a division at the next edge (E0), counts edges until ready_o, then
  // checks hold-in-END and the drop of start.
  task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [63:0] exp, input int exp_lat,
                         input bit scramble);
    int lat;
    bit stall_ok;
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = s;
    start_i      = 1'b1;
    #1;
    check({name, " stall_at_start"}, 64'(stallreg_from_div), 64'd1);
    @(posedge clk); #1;
    if (scramble) begin
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = ~s;
    end
    lat      = 0;
    stall_ok = 1'b1;
    while (!ready_o && lat < 40) begin
      if (!stallreg_from_div) stall_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " stall_while_busy"}, 64'(stall_ok), 64'd1);
    check({name, " result"}, result_o, exp);
    @(posedge clk); #1;
    check({name, " end_hold_ready"}, 64'({ready_o, stallreg_from_div}), 64'b10);
    check({name, " end_hold_result"}, result_o, exp);
    start_i = 1'b0;
    @(posedge clk); #1;
    check({name, " drop_ready"}, 64'(ready_o), 64'd0);
    check({name, " drop_result"}, result_o, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{"divu_100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33};
    vecs[1] = '{"div_m7_2", 32'hffff_fff9, 32'd2, 1'b1, {32'hffff_ffff, 32'hffff_fffd}, 33};
    vecs[2] = '{"div_7_m2", 32'd7, 32'hffff_fffe, 1'b1, {32'd1, 32'hffff_fffd}, 33};
    vecs[3] = '{"div_ovf", 32'h8000_0000, 32'hffff_ffff, 1'b1, {32'd0, 32'h8000_0000}, 33};
    vecs[4] = '{"divu_max_1", 32'hffff_ffff, 32'd1, 1'b0, {32'd0, 32'hffff_ffff}, 33};
    vecs[5] = '{"div_by_zero", 32'd5, 32'd0, 1'b1, 64'd0, 1};

    #12;
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    check("reset_stall", 64'(stallreg_from_div), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_div(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp, vecs[i].lat, 1'b1);
    end

    // Annul at edge 10 of ON, then restart straight away.
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #1;
    end
    check("annul_ready_before", 64'(ready_o), 64'd0);
    annul_i = 1'b1;
    #1;
    check("annul_stall", 64'(stallreg_from_div), 64'd0);
    @(posedge clk); #1;
    check("annul_ready_after", 64'(ready_o), 64'd0);
    annul_i = 1'b0;
    run_div("restart_9_3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, 1'b0);

    // Annul during BYZERO.
    opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b1;
    @(posedge clk); #1;
    check("annul_byzero_ready", 64'(ready_o), 64'd0);
    annul_i = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;

    // Annul held in IDLE blocks the start.
    opdata1_i = 32'd9; opdata2_i = 32'd3; start_i = 1'b1; annul_i = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("annul_idle_ready", 64'(ready_o), 64'd0);
    annul_i = 1'b0;
    run_div("after_idle_annul", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, 1'b0);

    // Asynchronous reset mid-ON.
    opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_on_ready", 64'(ready_o), 64'd0);
    check("rst_on_result", result_o, 64'd0);
    start_i = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_div("after_rst_on", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, 1'b0);

    // Asynchronous reset while ready_o is high.
    opdata1_i = 32'd123; opdata2_i = 32'd10; signed_div_i = 1'b0; start_i = 1'b1;
    repeat (35) @(posedge clk);
    #1;
    check("pre_rst_end_result", result_o, {32'd3, 32'd12});
    #2 reset_n = 1'b0;
    #1;
    check("rst_end_ready", 64'(ready_o), 64'd0);
    check("rst_end_result", result_o, 64'd0);
    start_i = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Random operands against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 15));
        3:       b = -32'($urandom_range(1, 15));
        4:       b = 32'hffff_ffff;
        default: b = $urandom;
      endcase
      if (i % 15 == 0) a = 32'h8000_0000;
      run_div($sformatf("rand%0d", i), a, b, s, ref_div(a, b, s), (b == 32'd0) ? 1 : 33, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
